// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   RXD         serial line, asynchronous to CLK, idles high
//   PARITY_MODE 0 = even, 1 = odd; latched when the start bit is confirmed
//   DOUT        last received byte, held until the next frame completes
//   VALID       one-cycle strobe: DOUT and error flags updated
//   PARITY_ERR  parity mismatch on the frame flagged by VALID
//   FRAME_ERR   stop bit sampled low on the frame flagged by VALID
//   BUSY        high from start-bit detection until the frame completes
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       PARITY_MODE,
  output logic [7:0] DOUT,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  localparam int unsigned CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             mode_q, mode_d;
  logic             perr_flag_q, perr_flag_d;
  logic [7:0]       dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync2_q, sync3_q;

  logic rx_s;
  logic rx_fall;

  // Two-flop synchroniser plus one delay stage for edge detection; idle-high reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = sync3_q & ~sync2_q;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      perr_flag_q <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      perr_flag_q <= perr_flag_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic; counter restarts at every sample point
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    perr_flag_d = perr_flag_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = S_START;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        // Re-check mid start bit so short glitches are rejected
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            mode_d    = PARITY_MODE;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          perr_flag_d = rx_s ^ (^shift_q) ^ mode_q;
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        // Registered outputs land one cycle after the stop sample
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          dout_d  = shift_q;
          perr_d  = perr_flag_q;
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          if (rx_s) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Keeps a break condition from looking like a new start bit
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign DOUT       = dout_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven by the bench, expected
// bytes/flags queued at drive time and compared on every VALID strobe.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned BIT       = CLK_FREQ / BAUD_RATE;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       RXD;
  logic       PARITY_MODE;
  logic [7:0] DOUT;
  logic       VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       BUSY;

  exp_t sb[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   valid_cnt = 0;
  logic valid_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXD        (RXD),
    .PARITY_MODE(PARITY_MODE),
    .DOUT       (DOUT),
    .VALID      (VALID),
    .PARITY_ERR (PARITY_ERR),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every VALID must match the oldest queued expectation
  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      valid_cnt++;
      if (valid_prev) check("valid_width", 32'(1), 32'(0));
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", 32'(DOUT), 32'(e.data));
        check("parity_err", 32'(PARITY_ERR), 32'(e.perr));
        check("frame_err", 32'(FRAME_ERR), 32'(e.ferr));
      end
    end
    valid_prev = VALID;
  end

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (BIT) @(negedge CLK);
  endtask

  // Expected flags computed from the line bits and the receiver's parity mode
  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.perr = par ^ (^d) ^ PARITY_MODE;
    e.ferr = ~stop;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    expect_frame(d, par, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    check("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string msg;
    int    v0;
    logic  saw_busy;

    RST = 1'b0;
    RXD = 1'b1;
    PARITY_MODE = 1'b0;
    repeat (100) @(negedge CLK);
    check("rst_dout", 32'(DOUT), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_dout", 32'(DOUT), 32'h00);
    check("post_rst_valid", 32'(VALID), 32'(0));
    check("post_rst_perr", 32'(PARITY_ERR), 32'(0));
    check("post_rst_ferr", 32'(FRAME_ERR), 32'(0));
    check("post_rst_busy", 32'(BUSY), 32'(0));
    check("post_rst_vcnt", 32'(valid_cnt), 32'(0));

    // Back-to-back message, even parity, no idle gaps
    msg = "Welcome to Inchon";
    v0 = valid_cnt;
    for (int i = 0; i < msg.len(); i++) begin
      logic [7:0] c;
      c = msg[i];
      send_frame(c, ^c, 1'b1);
    end
    wait_drain(4 * BIT);
    check("msg_valid_count", 32'(valid_cnt - v0), 32'(17));
    check("msg_idle_busy", 32'(BUSY), 32'(0));

    // Wrong parity: receiver expects odd, line carries even
    repeat (2 * BIT) @(negedge CLK);
    PARITY_MODE = 1'b1;
    v0 = valid_cnt;
    send_frame(8'hA5, ^(8'hA5), 1'b1);
    wait_drain(4 * BIT);
    check("perr_valid_count", 32'(valid_cnt - v0), 32'(1));
    PARITY_MODE = 1'b0;

    // Framing error followed by a held break
    repeat (2 * BIT) @(negedge CLK);
    v0 = valid_cnt;
    send_frame(8'h3C, ^(8'h3C), 1'b0);
    RXD = 1'b0;
    repeat (3 * BIT) @(negedge CLK);
    wait_drain(4 * BIT);
    check("break_busy_held", 32'(BUSY), 32'(1));
    RXD = 1'b1;
    repeat (5) @(negedge CLK);
    check("break_busy_release", 32'(BUSY), 32'(0));
    repeat (2 * BIT) @(negedge CLK);
    check("break_valid_count", 32'(valid_cnt - v0), 32'(1));

    // Short low glitch must be rejected at the start-bit sample
    v0 = valid_cnt;
    saw_busy = 1'b0;
    RXD = 1'b0;
    repeat (BIT / 4) @(negedge CLK);
    RXD = 1'b1;
    for (int i = 0; i < 2 * BIT; i++) begin
      if (BUSY) saw_busy = 1'b1;
      @(negedge CLK);
    end
    check("glitch_saw_busy", 32'(saw_busy), 32'(1));
    check("glitch_busy_end", 32'(BUSY), 32'(0));
    check("glitch_valid_count", 32'(valid_cnt - v0), 32'(0));
    check("glitch_dout_held", 32'(DOUT), 32'h3C);

    // Reset in the middle of data bit 3 aborts the frame silently
    v0 = valid_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    RXD = 1'b1;
    repeat (BIT / 2) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    repeat (3 * BIT) @(negedge CLK);
    check("abort_valid_count", 32'(valid_cnt - v0), 32'(0));
    check("abort_dout", 32'(DOUT), 32'h00);
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_ferr", 32'(FRAME_ERR), 32'(0));

    v0 = valid_cnt;
    send_frame(8'h81, ^(8'h81), 1'b1);
    wait_drain(4 * BIT);
    check("recover_valid_count", 32'(valid_cnt - v0), 32'(1));
    check("recover_dout_held", 32'(DOUT), 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
